// File: rtl/serial_pattern_detector.sv
// Programmable serial pattern detector.
// Shifts in one bit per valid cycle, compares the newest PAT_W bits against a
// loaded pattern under a don't-care mask, and flags a match in the same cycle
// as the final bit. Supports overlapping and non-overlapping detection and
// keeps a saturating hit counter with a sticky saturation flag.
// PAT_W must lie in 2..32.
module serial_pattern_detector #(
  parameter int unsigned PAT_W = 7,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serIn,
  input  logic             inValid,
  input  logic             load,
  input  logic [PAT_W-1:0] patIn,
  input  logic [PAT_W-1:0] maskIn,
  input  logic             overlap,
  input  logic             clrCount,
  output logic             w,
  output logic [CNT_W-1:0] hitCount,
  output logic             sat
);

  // fill counts 0..PAT_W-1, so $clog2(PAT_W) bits are always enough.
  localparam int unsigned     FillW    = $clog2(PAT_W);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [PAT_W-1:0] cand;
  logic             shift_en;
  logic             hist_full;
  logic             bits_equal;
  logic             match;

  // Match decode: history plus the bit arriving this cycle, compared under mask.
  always_comb begin
    cand       = {hist_q, serIn};
    shift_en   = inValid & ~load;
    hist_full  = (fill_q == FillFull);
    bits_equal = ~|((cand ^ pat_q) & mask_q);
    match      = shift_en & hist_full & bits_equal & ~rst;
  end

  assign w        = match;
  assign hitCount = cnt_q;
  assign sat      = sat_q;

  // Pattern, mask and history next state; load takes priority over shifting.
  always_comb begin
    pat_d  = pat_q;
    mask_d = mask_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (load) begin
      pat_d  = patIn;
      mask_d = maskIn;
      hist_d = '0;
      fill_d = '0;
    end else if (inValid) begin
      hist_d = cand[PAT_W-2:0];
      if (match && !overlap) begin
        // Non-overlap: history bits are kept but ignored until refilled.
        fill_d = '0;
      end else if (!hist_full) begin
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  // Hit counter next state; clear beats a simultaneous increment.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clrCount) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (match && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sat_d = sat_q | (cnt_d == CntMax);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      mask_q <= '0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      mask_q <= mask_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Scoreboard bench for serial_pattern_detector. Three instances cover the
// default geometry, a 4-bit pattern and a 2-bit counter; only the selected
// instance sees inValid/load. Drivers push expected responses, the monitor
// pops and compares on the falling edge.
module tb_serial_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       do_load = 1'b0;
  logic       overlap = 1'b0;
  logic       clr_count = 1'b0;
  logic       chk_cnt = 1'b0;
  int         sel = 0;
  logic [6:0] pat_in7 = '0;
  logic [6:0] mask_in7 = '0;
  logic [3:0] pat_in4 = '0;
  logic [3:0] mask_in4 = '0;

  logic       iv7, iv4, ivc, ld7, ld4, ldc;
  logic       w7, w4, wc, sat7, sat4, satc;
  logic [7:0] cnt7, cnt4;
  logic [1:0] cntc;

  assign iv7 = in_valid && (sel == 0);
  assign iv4 = in_valid && (sel == 1);
  assign ivc = in_valid && (sel == 2);
  assign ld7 = do_load && (sel == 0);
  assign ld4 = do_load && (sel == 1);
  assign ldc = do_load && (sel == 2);

  always #5 clk = ~clk;

  serial_pattern_detector #(.PAT_W(7), .CNT_W(8)) u_dut7 (
    .clk(clk), .rst(rst), .serIn(ser_in), .inValid(iv7), .load(ld7), .patIn(pat_in7),
    .maskIn(mask_in7), .overlap(overlap), .clrCount(clr_count), .w(w7), .hitCount(cnt7),
    .sat(sat7)
  );

  serial_pattern_detector #(.PAT_W(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .serIn(ser_in), .inValid(iv4), .load(ld4), .patIn(pat_in4),
    .maskIn(mask_in4), .overlap(overlap), .clrCount(clr_count), .w(w4), .hitCount(cnt4),
    .sat(sat4)
  );

  serial_pattern_detector #(.PAT_W(7), .CNT_W(2)) u_dutc (
    .clk(clk), .rst(rst), .serIn(ser_in), .inValid(ivc), .load(ldc), .patIn(pat_in7),
    .maskIn(mask_in7), .overlap(overlap), .clrCount(clr_count), .w(wc), .hitCount(cntc),
    .sat(satc)
  );

  typedef struct {
    bit is_cnt;
    bit w;
    int cnt;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic cur_w, cur_sat;
  int   cur_cnt;
  exp_t e;

  // Output mux for whichever instance is currently under test.
  always_comb begin
    cur_w   = w7;
    cur_cnt = int'(cnt7);
    cur_sat = sat7;
    case (sel)
      1: begin cur_w = w4; cur_cnt = int'(cnt4); cur_sat = sat4; end
      2: begin cur_w = wc; cur_cnt = int'(cntc); cur_sat = satc; end
      default: ;
    endcase
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s (inst %0d, t=%0t): got %0d, expected %0d", name, sel, $time, act,
               expv);
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("w_during_reset", int'(cur_w), 0);
    end else if (chk_cnt) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow_cnt", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("hitCount", cur_cnt, e.cnt);
        check("sat", int'(cur_sat), int'(e.sat));
      end
    end else if (in_valid && !do_load) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow_w", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("w", int'(cur_w), int'(e.w));
      end
    end else begin
      check("w_quiet", int'(cur_w), 0);
    end
  end

  task automatic drive_bit(input logic b, input bit ew, input logic clr = 1'b0);
    exp_t x;
    x = '{is_cnt: 1'b0, w: ew, cnt: 0, sat: 1'b0};
    exp_q.push_back(x);
    ser_in    = b;
    in_valid  = 1'b1;
    clr_count = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  // Bits and expected flags are given MSB-first (first bit sent = bit n-1).
  task automatic send_seq(input logic [31:0] bits, input int n, input logic [31:0] ew);
    for (int k = 0; k < n; k++) begin
      drive_bit(bits[n-1-k], ew[n-1-k]);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Load with inValid high so the discarded bit and forced w=0 are exercised.
  task automatic load_pat(input logic [6:0] p, input logic [6:0] m);
    pat_in7  = p;
    mask_in7 = m;
    pat_in4  = p[3:0];
    mask_in4 = m[3:0];
    do_load  = 1'b1;
    in_valid = 1'b1;
    ser_in   = 1'b1;
    @(posedge clk);
    #1;
    do_load  = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_cnt(input int c, input bit s);
    exp_t x;
    x = '{is_cnt: 1'b1, w: 1'b0, cnt: c, sat: s};
    exp_q.push_back(x);
    chk_cnt = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      check_cnt(0, 1'b0);
    end

    // Default geometry.
    sel = 0;
    overlap = 1'b0;
    load_pat(7'b0111110, 7'h7F);
    send_seq(32'b0111110, 7, 32'b0000001);
    check_cnt(1, 1'b0);

    overlap = 1'b1;
    load_pat(7'b0111110, 7'h7F);
    send_seq(32'b0111110111110, 13, 32'b0000001000001);
    check_cnt(3, 1'b0);

    overlap = 1'b0;
    load_pat(7'b0111110, 7'h7F);
    send_seq(32'b0111110111110, 13, 32'b0000001000000);
    check_cnt(4, 1'b0);

    // End bits are don't-care; then the same match across inValid gaps.
    load_pat(7'b0111110, 7'b0111110);
    send_seq(32'b1111111, 7, 32'b0000001);
    check_cnt(5, 1'b0);
    send_seq(32'b111, 3, 32'b000);
    idle(2);
    send_seq(32'b1111, 4, 32'b0001);
    check_cnt(6, 1'b0);

    // Empty mask, non-overlap: one match every 7 valid bits.
    load_pat(7'b0000000, 7'b0000000);
    send_seq(32'b10110010011101, 14, 32'b00000010000001);
    check_cnt(8, 1'b0);

    // Reload after a partial pattern restarts the fill.
    load_pat(7'b0111110, 7'h7F);
    send_seq(32'b0111, 4, 32'b0000);
    load_pat(7'b0111110, 7'h7F);
    send_seq(32'b110, 3, 32'b000);
    send_seq(32'b0111110, 7, 32'b0000001);
    check_cnt(9, 1'b0);

    // Overlap with empty mask, then reset while the history is full.
    overlap = 1'b1;
    load_pat(7'b0000000, 7'b0000000);
    send_seq(32'b1010101, 7, 32'b0000001);
    send_seq(32'b0111, 4, 32'b1111);
    check_cnt(14, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    ser_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check_cnt(0, 1'b0);
    // Reset clears the mask, so any 7 fresh bits match.
    send_seq(32'b1100110, 7, 32'b0000001);
    load_pat(7'b0000000, 7'b0000000);
    send_seq(32'b0011001, 7, 32'b0000001);
    check_cnt(2, 1'b0);

    // 4-bit pattern instance.
    sel = 1;
    overlap = 1'b1;
    load_pat(7'b0001010, 7'b0001111);
    send_seq(32'b1010101, 7, 32'b0001010);
    check_cnt(2, 1'b0);
    overlap = 1'b0;
    load_pat(7'b0001010, 7'b0001111);
    send_seq(32'b1010101, 7, 32'b0001000);
    check_cnt(3, 1'b0);

    // 2-bit counter instance: saturation and clear-on-match.
    sel = 2;
    overlap = 1'b1;
    load_pat(7'b0000000, 7'b0000000);
    send_seq(32'b000000000, 9, 32'b000000111);
    check_cnt(3, 1'b1);
    send_seq(32'b11, 2, 32'b11);
    check_cnt(3, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b1);
    check_cnt(0, 1'b0);
    drive_bit(1'b1, 1'b1);
    check_cnt(1, 1'b0);

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
